// File: rtl/counter_arbiter_pkg.sv
// rtl/counter_arbiter_pkg.sv - shared types and default parameters for counter_arbiter
package counter_arb_pkg;

  typedef enum logic [1:0] {OP_NOP, OP_INC, OP_DEC, OP_CLR} cnt_op_t;
  typedef enum logic {S_IDLE, S_LOCKED} arb_state_t;

  localparam int DEFAULT_NREQ     = 4;
  localparam int DEFAULT_MAX_LOCK = 16;
  // Wide enough for the largest allowed MAX_LOCK (255).
  localparam int LOCK_CNT_W       = 8;

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// rtl/counter_arbiter_rr_pick.sv - combinational rotate-priority picker for counter_arbiter
module rr_pick
  import counter_arb_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int k;

  // Scan from the pointer, wrapping modulo NREQ; the first requester seen wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    k        = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_i) + i) % NREQ;
      if (!any_o && req_i[k]) begin
        any_o       = 1'b1;
        onehot_o[k] = 1'b1;
        idx_o       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin arbiter with burst lock driving a shared up/down counter (option: COUNTER_ARB_SAT_EN)
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ     = DEFAULT_NREQ,
  parameter int MAX_LOCK = DEFAULT_MAX_LOCK,
  parameter int WIDTH    = 32,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [NREQ-1:0]   lock,
  input  logic [WIDTH-1:0]  count,
  output logic              cnt_inc,
  output logic              cnt_dec,
  output logic              cnt_clr,
  output logic [NREQ-1:0]   gnt,
  output logic [IW-1:0]     owner,
  output logic              locked
`ifdef COUNTER_ARB_SAT_EN
  ,
  output logic              sat
`endif
);

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic                  inc_q, inc_d;
  logic                  dec_q, dec_d;
  logic                  clr_q, clr_d;
  logic                  sat_q, sat_d;

  logic [NREQ-1:0]       pick_onehot;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  grant;
  logic [IW-1:0]         gidx;
  logic [1:0]            op_a [NREQ];

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
    if (idx == IW'(NREQ - 1)) return '0;
    return idx + IW'(1);
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Split the packed opcode bus into one 2-bit opcode per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = op[2*i +: 2];
    end
  end

  // Next-state: IDLE arbitrates round-robin, LOCKED keeps granting the owner until it lets go or hits MAX_LOCK.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    clr_d      = 1'b0;
    sat_d      = 1'b0;
    grant      = 1'b0;
    gidx       = owner_q;

    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant = 1'b1;
          gidx  = pick_idx;
          gnt_d = pick_onehot;
          ptr_d = ptr_after(pick_idx);
          if (lock[pick_idx]) begin
            state_d    = S_LOCKED;
            lock_cnt_d = LOCK_CNT_W'(1);
          end
        end
      end
      S_LOCKED: begin
        if (req[owner_q] && lock[owner_q] && (lock_cnt_q < MAX_LOCK_C)) begin
          grant          = 1'b1;
          gidx           = owner_q;
          gnt_d[owner_q] = 1'b1;
          lock_cnt_d     = lock_cnt_q + LOCK_CNT_W'(1);
        end else begin
          // Releasing (voluntary or forced) moves the pointer past the owner.
          state_d    = S_IDLE;
          ptr_d      = ptr_after(owner_q);
          lock_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant) begin
      owner_d = gidx;
      case (cnt_op_t'(op_a[gidx]))
`ifdef COUNTER_ARB_SAT_EN
        OP_INC: if (count == '1) sat_d = 1'b1; else inc_d = 1'b1;
        OP_DEC: if (count == '0) sat_d = 1'b1; else dec_d = 1'b1;
`else
        OP_INC: inc_d = 1'b1;
        OP_DEC: dec_d = 1'b1;
`endif
        OP_CLR: clr_d = 1'b1;
        default: ;
      endcase
    end
  end

`ifndef COUNTER_ARB_SAT_EN
  logic unused_count;
  assign unused_count = ^count;
`endif

  // State, pointer, lock counter and registered grant/strobe outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      clr_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      clr_q      <= clr_d;
      sat_q      <= sat_d;
    end
  end

  assign gnt     = gnt_q;
  assign cnt_inc = inc_q;
  assign cnt_dec = dec_q;
  assign cnt_clr = clr_q;
  assign owner   = owner_q;
  assign locked  = (state_q == S_LOCKED);
`ifdef COUNTER_ARB_SAT_EN
  assign sat     = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - scoreboard bench for counter_arbiter (honours COUNTER_ARB_SAT_EN)
module tb_counter_arbiter;

  localparam int ST_NONE = 0;
  localparam int ST_INC  = 1;
  localparam int ST_DEC  = 2;
  localparam int ST_CLR  = 3;

  typedef struct packed {
    logic [3:0] gnt;
    logic       inc;
    logic       dec;
    logic       clr;
    logic [1:0] owner;
    logic       locked;
    logic       sat;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [3:0]  lock;
  logic [31:0] count;
  logic        cnt_inc, cnt_dec, cnt_clr;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        locked;
`ifdef COUNTER_ARB_SAT_EN
  logic        sat;
`endif

  logic        load;
  logic [31:0] load_val;

  int   tests = 0;
  int   fails = 0;
  obs_t q[$];

  always #5 clk = ~clk;

  counter_arbiter #(.NREQ(4), .MAX_LOCK(16), .WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .op      (op),
    .lock    (lock),
    .count   (count),
    .cnt_inc (cnt_inc),
    .cnt_dec (cnt_dec),
    .cnt_clr (cnt_clr),
    .gnt     (gnt),
    .owner   (owner),
    .locked  (locked)
`ifdef COUNTER_ARB_SAT_EN
    ,
    .sat     (sat)
`endif
  );

  // Downstream counter driven by the arbiter strobes; load lets the bench preset it.
  always @(posedge clk or negedge reset) begin
    if (!reset)       count <= 32'd0;
    else if (load)    count <= load_val;
    else if (cnt_clr) count <= 32'd0;
    else if (cnt_inc) count <= count + 32'd1;
    else if (cnt_dec) count <= count - 32'd1;
  end

  function automatic obs_t observe();
    obs_t a;
    a.gnt    = gnt;
    a.inc    = cnt_inc;
    a.dec    = cnt_dec;
    a.clr    = cnt_clr;
    a.owner  = owner;
    a.locked = locked;
`ifdef COUNTER_ARB_SAT_EN
    a.sat    = sat;
`else
    a.sat    = 1'b0;
`endif
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_g(input logic [3:0] g, input int st, input logic [1:0] own,
                          input logic lk, input logic s);
    obs_t e;
    e.gnt    = g;
    e.inc    = (st == ST_INC);
    e.dec    = (st == ST_DEC);
    e.clr    = (st == ST_CLR);
    e.owner  = own;
    e.locked = lk;
    e.sat    = s;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    obs_t a;
    obs_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        a = observe();
        tests++;
        if (a.gnt != 4'b0000) begin
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_grant: got %h expected no grant", a);
          end else begin
            e = q.pop_front();
            if (a !== e) begin
              fails++;
              $display("FAIL grant_seq: got %h expected %h", a, e);
            end
          end
        end else if (a.inc || a.dec || a.clr || a.sat) begin
          fails++;
          $display("FAIL strobe_without_gnt: got %h expected no strobe", a);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req = '0; op = '0; lock = '0; load = 1'b0; load_val = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_strobes", 32'({cnt_inc, cnt_dec, cnt_clr}), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    reset = 1'b1;

    // Two requesters alternate, all INC
    req = 4'b0101; op = 8'h55;
    expect_g(4'b0001, ST_INC, 2'd0, 1'b0, 1'b0); tick();
    expect_g(4'b0100, ST_INC, 2'd2, 1'b0, 1'b0); tick();
    expect_g(4'b0001, ST_INC, 2'd0, 1'b0, 1'b0); tick();
    expect_g(4'b0100, ST_INC, 2'd2, 1'b0, 1'b0); tick();
    req = '0; tick(); tick();
    check("count_after_alt", count, 32'd4);

    // NOP grant moves pointer from 3 to 0
    req = 4'b1000; op = 8'h00;
    expect_g(4'b1000, ST_NONE, 2'd3, 1'b0, 1'b0); tick();

    // Full round, mixed ops: INC, DEC, INC, CLR
    req = 4'b1111; op = 8'b11_01_10_01;
    expect_g(4'b0001, ST_INC, 2'd0, 1'b0, 1'b0); tick();
    expect_g(4'b0010, ST_DEC, 2'd1, 1'b0, 1'b0); tick();
    expect_g(4'b0100, ST_INC, 2'd2, 1'b0, 1'b0); tick();
    expect_g(4'b1000, ST_CLR, 2'd3, 1'b0, 1'b0); tick();
    // Pointer back at 0: scan 0,1 picks requester 1 over 3
    req = 4'b1010; op = 8'h00;
    expect_g(4'b0010, ST_NONE, 2'd1, 1'b0, 1'b0); tick();
    req = '0; tick(); tick();
    check("count_after_round", count, 32'd0);

    // Locked burst from requester 2 while requester 1 waits
    req = 4'b0110; lock = 4'b0100; op = 8'h10;
    for (int i = 0; i < 16; i++) begin
      expect_g(4'b0100, ST_INC, 2'd2, 1'b1, 1'b0); tick();
    end
    tick();
    check("lock_release_gnt", 32'(gnt), 32'h0);
    check("lock_release_locked", 32'(locked), 32'h0);
    expect_g(4'b0010, ST_NONE, 2'd1, 1'b0, 1'b0); tick();
    expect_g(4'b0100, ST_INC, 2'd2, 1'b1, 1'b0); tick();
    expect_g(4'b0100, ST_INC, 2'd2, 1'b1, 1'b0); tick();
    req = '0; lock = '0; tick();
    check("lock_drop_locked", 32'(locked), 32'h0);
    tick();
    check("count_after_lock", count, 32'd18);

    // Reset in the middle of a locked burst from requester 1
    req = 4'b0010; lock = 4'b0010; op = 8'h04;
    expect_g(4'b0010, ST_INC, 2'd1, 1'b1, 1'b0); tick();
    expect_g(4'b0010, ST_INC, 2'd1, 1'b1, 1'b0); tick();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_inc", 32'(cnt_inc), 32'h0);
    check("async_rst_locked", 32'(locked), 32'h0);
    check("async_rst_owner", 32'(owner), 32'h0);
    tick();
    check("rst_held_gnt", 32'(gnt), 32'h0);
    req = 4'b0101; lock = '0; op = 8'h11; reset = 1'b1;
    expect_g(4'b0001, ST_INC, 2'd0, 1'b0, 1'b0); tick();
    req = '0; tick();

    // DEC at count 0
    load = 1'b1; load_val = 32'h0; tick(); load = 1'b0;
    req = 4'b0001; op = 8'h02;
`ifdef COUNTER_ARB_SAT_EN
    expect_g(4'b0001, ST_NONE, 2'd0, 1'b0, 1'b1);
`else
    expect_g(4'b0001, ST_DEC, 2'd0, 1'b0, 1'b0);
`endif
    tick();
    req = '0; tick(); tick();
`ifdef COUNTER_ARB_SAT_EN
    check("count_after_dec0", count, 32'h0);
`else
    check("count_after_dec0", count, 32'hFFFF_FFFF);
`endif

    // INC at all-ones
    load = 1'b1; load_val = 32'hFFFF_FFFF; tick(); load = 1'b0;
    req = 4'b0001; op = 8'h01;
`ifdef COUNTER_ARB_SAT_EN
    expect_g(4'b0001, ST_NONE, 2'd0, 1'b0, 1'b1);
`else
    expect_g(4'b0001, ST_INC, 2'd0, 1'b0, 1'b0);
`endif
    tick();
    req = '0; tick(); tick();
`ifdef COUNTER_ARB_SAT_EN
    check("count_after_incmax", count, 32'hFFFF_FFFF);
`else
    check("count_after_incmax", count, 32'h0);
`endif

    // Single requester held: granted every cycle
    req = 4'b0001; op = 8'h00;
    expect_g(4'b0001, ST_NONE, 2'd0, 1'b0, 1'b0); tick();
    expect_g(4'b0001, ST_NONE, 2'd0, 1'b0, 1'b0); tick();
    expect_g(4'b0001, ST_NONE, 2'd0, 1'b0, 1'b0); tick();
    req = '0; tick(); tick();

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
